// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: widths, opcode encodings and FSM states.
package alu_seq_pkg;

  localparam int DATA_W  = 8;
  localparam int SEL_W   = 3;
  localparam int COUNT_W = 16;

  localparam logic [SEL_W-1:0] OP_ADD        = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB        = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND        = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR         = 3'b011;
  localparam logic [SEL_W-1:0] OP_ANDN       = 3'b100;
  localparam logic [SEL_W-1:0] OP_LAST_LEGAL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes above ANDN are passed to the ALU unchanged but flagged in the response.
  function automatic logic is_illegal(input logic [SEL_W-1:0] op);
    return op > OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command port, the ALU operand/result bus and the response port.
// Handshake rule for cmd_* and rsp_*: a transfer happens on a rising edge where
// valid and ready are both high; once valid is raised the payload is held stable
// until that transfer, and ready may be driven without looking at valid.
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [SEL_W-1:0]  cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_acc;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;

  // Sequencer side: takes commands, drives the ALU, returns responses.
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    input  alu_result, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  // Surrounding side: control logic issuing commands plus the combinational ALU.
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    output alu_result, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

endinterface

// File: rtl/alu_seq_rsp_slice.sv
// Response holding register: captures one ALU result and presents it on a
// valid/ready port, holding it stable until the consumer takes it.
module alu_seq_rsp_slice
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_result,
  input  logic              load_zero,
  input  logic              load_illegal,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              rsp_fire
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  // Load wins over hand-off; payload is only rewritten on load so it stays put while waiting.
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (load) begin
      valid_d   = 1'b1;
      result_d  = load_result;
      zero_d    = load_zero;
      illegal_d = load_illegal;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  // Response register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign rsp_valid   = valid_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;
  assign rsp_fire    = valid_q & rsp_ready;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one command, issues it to the external ALU for one
// cycle, captures the result and hands it back on the response port.
// Optional build macro ALU_SEQ_ACCUM_EN adds an accumulator that can replace
// operand A (selected per command by cmd_acc).
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.master bus,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count,
  output state_e             state_dbg
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic [DATA_W-1:0]  operand_a;
  logic               capture;
  logic               rsp_fire;

`ifdef ALU_SEQ_ACCUM_EN
  logic [DATA_W-1:0]  acc_q, acc_d;

  // Operand A comes from the accumulator when the command asks for it.
  always_comb begin
    operand_a = bus.cmd_acc ? acc_q : bus.cmd_a;
  end

  // Accumulator follows every captured ALU result.
  always_comb begin
    acc_d = acc_q;
    if (capture) acc_d = bus.alu_result;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  logic unused_cmd_acc;
  assign unused_cmd_acc = bus.cmd_acc;

  // Without the accumulator operand A is always the command's own A.
  always_comb begin
    operand_a = bus.cmd_a;
  end
`endif

  // Next-state and operand register updates; ALU inputs only change on accept.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = ST_EXEC;
          alu_a_d   = operand_a;
          alu_b_d   = bus.cmd_b;
          alu_sel_d = bus.cmd_op;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_fire) begin
          state_d    = ST_IDLE;
          op_count_d = op_count_q + COUNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      op_count_q <= op_count_d;
    end
  end

  // The ALU output is sampled at the end of the single EXEC cycle.
  assign capture = (state_q == ST_EXEC);

  alu_seq_rsp_slice u_rsp (
    .clk          (clk),
    .rst          (rst),
    .load         (capture),
    .load_result  (bus.alu_result),
    .load_zero    (bus.alu_zero),
    .load_illegal (is_illegal(alu_sel_q)),
    .rsp_ready    (bus.rsp_ready),
    .rsp_valid    (bus.rsp_valid),
    .rsp_result   (bus.rsp_result),
    .rsp_zero     (bus.rsp_zero),
    .rsp_illegal  (bus.rsp_illegal),
    .rsp_fire     (rsp_fire)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign busy          = (state_q != ST_IDLE);
  assign op_count      = op_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: hosts a combinational ALU, drives directed and
// random commands, and checks every response against an expected queue.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic               clk;
  logic               rst;
  logic               busy;
  logic [COUNT_W-1:0] op_count;
  state_e             state_dbg;

  int n_cmp;
  int n_err;

  logic [9:0]  exp_q[$];
  logic [15:0] cnt_m;
  logic [7:0]  acc_m;

  alu_op_sequencer_if bus_if ();

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic straight from the opcode table (8-bit wrap, illegal -> 0).
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      3'd0:    r = (int'(a) + int'(b)) % 256;
      3'd1:    r = (int'(a) - int'(b) + 256) % 256;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a & ~b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // The ALU the sequencer talks to.
  always_comb begin
    bus_if.alu_result = ref_alu(bus_if.alu_sel, bus_if.alu_a, bus_if.alu_b);
    bus_if.alu_zero   = (bus_if.alu_result == 8'h00);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full command/response transaction; hold = cycles rsp_ready stays low in RESP,
  // want >= 0 additionally pins the result to a hand-computed constant.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic acc, input int hold, input int want);
    logic [7:0] ea;
    logic [7:0] er;
    logic [9:0] e;
    check_eq("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    bus_if.cmd_acc   = acc;
    @(posedge clk);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 3'($urandom);
    bus_if.cmd_a     = 8'($urandom);
    bus_if.cmd_b     = 8'($urandom);
    bus_if.cmd_acc   = 1'($urandom);
    ea = a;
`ifdef ALU_SEQ_ACCUM_EN
    if (acc) ea = acc_m;
`endif
    er = ref_alu(op, ea, b);
    exp_q.push_back({(op > 3'd4), (er == 8'h00), er});
    check_eq("alu_a_exec", 32'(bus_if.alu_a), 32'(ea));
    check_eq("alu_b_exec", 32'(bus_if.alu_b), 32'(b));
    check_eq("alu_sel_exec", 32'(bus_if.alu_sel), 32'(op));
    check_eq("rsp_valid_n1", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("busy_exec", 32'(busy), 32'd1);
    check_eq("cmd_ready_exec", 32'(bus_if.cmd_ready), 32'd0);
    bus_if.rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("rsp_valid_n2", 32'(bus_if.rsp_valid), 32'd1);
    check_eq("rsp_result", 32'(bus_if.rsp_result), 32'(e[7:0]));
    check_eq("rsp_zero", 32'(bus_if.rsp_zero), 32'(e[8]));
    check_eq("rsp_illegal", 32'(bus_if.rsp_illegal), 32'(e[9]));
    if (want >= 0) check_eq("rsp_result_const", 32'(bus_if.rsp_result), 32'(want));
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (i < hold - 1) begin
        check_eq("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_eq("hold_result", 32'(bus_if.rsp_result), 32'(e[7:0]));
        check_eq("hold_zero", 32'(bus_if.rsp_zero), 32'(e[8]));
        check_eq("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        check_eq("hold_op_count", 32'(op_count), 32'(cnt_m));
        check_eq("hold_alu_a", 32'(bus_if.alu_a), 32'(ea));
      end
    end
    if (hold == 0) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.rsp_ready = 1'b0;
    cnt_m = cnt_m + 16'd1;
    acc_m = er;
    check_eq("rsp_valid_done", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("op_count_done", 32'(op_count), 32'(cnt_m));
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("alu_sel_held", 32'(bus_if.alu_sel), 32'(op));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt_m = '0;
    acc_m = '0;
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.cmd_acc   = 1'b0;
    bus_if.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("rst_rsp_result", 32'(bus_if.rsp_result), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    check_eq("rst_alu_a", 32'(bus_if.alu_a), 32'd0);
    check_eq("rst_alu_sel", 32'(bus_if.alu_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(OP_ADD,  8'h05, 8'h03, 1'b0, 0, 8'h08);
    do_op(OP_SUB,  8'h03, 8'h03, 1'b0, 0, 8'h00);
    do_op(OP_SUB,  8'h00, 8'h01, 1'b0, 1, 8'hFF);
    do_op(OP_ANDN, 8'hF0, 8'hC3, 1'b0, 0, 8'h30);
    do_op(OP_AND,  8'hCC, 8'hAA, 1'b0, 2, 8'h88);
    do_op(OP_OR,   8'hCC, 8'hAA, 1'b0, 6, 8'hEE);
    do_op(3'b110,  8'hFF, 8'h01, 1'b0, 0, 8'h00);
`ifdef ALU_SEQ_ACCUM_EN
    do_op(OP_ADD,  8'h05, 8'h03, 1'b0, 0, 8'h08);
    do_op(OP_ADD,  8'h77, 8'h02, 1'b1, 0, 8'h0A);
`else
    do_op(OP_ADD,  8'h11, 8'h02, 1'b1, 0, 8'h13);
`endif

    // Reset while an op is in EXEC: dropped, no response, back to IDLE.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = OP_ADD;
    bus_if.cmd_a     = 8'h21;
    bus_if.cmd_b     = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    check_eq("exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = '0;
    acc_m = '0;
    check_eq("exec_rst_busy", 32'(busy), 32'd0);
    check_eq("exec_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("exec_rst_op_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("exec_rst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clk);
    end

    // Randomized traffic against the expected queue.
    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
